// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: credit-limited sequential fetch into a
// circular prefetch FIFO, with redirect flush and a delivered-instruction counter.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 5,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(4)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_rd,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              ir_valid,
  output logic [31:0]       ir_data,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              ir_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [15:0]       fetch_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic              r_running;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_pc;
  logic [PTR_W-1:0]  r_head, r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [15:0]       r_fetch_count;
  logic [31:0]       r_buf_data [DEPTH];
  logic [ADDR_W-1:0] r_buf_pc   [DEPTH];

  logic [CNT_W:0]    w_occ;
  logic              w_issue, w_push, w_pop, w_nonempty;

  // The in-flight read already owns a slot, so counting it here keeps pushes from overflowing.
  assign w_occ      = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
  assign w_issue    = r_running & ~redirect_valid & (w_occ < (CNT_W+1)'(DEPTH));
  assign w_push     = r_inflight & ~redirect_valid;
  assign w_nonempty = (r_count != '0);
  assign w_pop      = ir_valid & ir_ready;

  assign imem_rd     = w_issue;
  assign imem_addr   = r_pc;
  assign ir_valid    = w_nonempty & ~redirect_valid;
  assign ir_data     = w_nonempty ? r_buf_data[r_head] : 32'd0;
  assign ir_pc       = w_nonempty ? r_buf_pc[r_head]   : '0;
  assign fetch_count = r_fetch_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_running     <= 1'b0;
      r_inflight    <= 1'b0;
      r_pc          <= RESET_PC;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_fetch_count <= '0;
    end else begin
      r_running  <= 1'b1;
      r_inflight <= w_issue;
      if (w_pop) r_fetch_count <= r_fetch_count + 16'd1;
      if (redirect_valid) begin
        r_pc    <= redirect_pc;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_issue) r_pc   <= r_pc + ADDR_W'(1);
        if (w_push)  r_tail <= r_tail + PTR_W'(1);
        if (w_pop)   r_head <= r_head + PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_data[r_tail] <= imem_rdata;
      r_buf_pc[r_tail]   <= r_pc - ADDR_W'(1);
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed cycle table, reset/wrap corner cases,
// then random ready/redirect traffic checked at the transfer level.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_rd;
  logic [4:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        ir_valid;
  logic [31:0] ir_data;
  logic [4:0]  ir_pc;
  logic        ir_ready;
  logic        redirect_valid;
  logic [4:0]  redirect_pc;
  logic [15:0] fetch_count;

  int n_cmp = 0;
  int n_err = 0;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_rd(imem_rd), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .ir_valid(ir_valid), .ir_data(ir_data), .ir_pc(ir_pc),
    .ir_ready(ir_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [4:0] a);
    return 32'h1000_0000 + {27'd0, a};
  endfunction

  // Synchronous memory: data for a read appears the cycle after the strobe, junk otherwise.
  always @(posedge clk) imem_rdata <= imem_rd ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       rdy;
    logic       redir;
    logic [4:0] rpc;
    logic       e_rd;
    logic [4:0] e_addr;
    logic       e_vld;
    logic [4:0] e_pc;
    logic [15:0] e_fc;
  } vec_t;

  vec_t vecs [25];

  initial begin
    logic [4:0]  exp_pc;
    logic [15:0] exp_fc;
    int          since;
    bit          all_rdy;
    bit          got;

    vecs[0]  = '{0,0,0,  0,0, 0,0,  0};
    vecs[1]  = '{0,0,0,  1,4, 0,0,  0};
    vecs[2]  = '{0,0,0,  1,5, 0,0,  0};
    vecs[3]  = '{0,0,0,  1,6, 1,4,  0};
    vecs[4]  = '{0,0,0,  1,7, 1,4,  0};
    vecs[5]  = '{0,0,0,  0,0, 1,4,  0};
    vecs[6]  = '{0,0,0,  0,0, 1,4,  0};
    vecs[7]  = '{1,0,0,  0,0, 1,4,  0};
    vecs[8]  = '{1,0,0,  1,8, 1,5,  1};
    vecs[9]  = '{1,0,0,  1,9, 1,6,  2};
    vecs[10] = '{1,0,0,  1,10,1,7,  3};
    vecs[11] = '{0,0,0,  1,11,1,8,  4};
    vecs[12] = '{0,1,20, 0,0, 0,0,  4};
    vecs[13] = '{1,0,0,  1,20,0,0,  4};
    vecs[14] = '{1,0,0,  1,21,0,0,  4};
    vecs[15] = '{1,0,0,  1,22,1,20, 4};
    vecs[16] = '{1,0,0,  1,23,1,21, 5};
    vecs[17] = '{1,0,0,  1,24,1,22, 6};
    vecs[18] = '{1,1,30, 0,0, 0,0,  7};
    vecs[19] = '{1,0,0,  1,30,0,0,  7};
    vecs[20] = '{1,0,0,  1,31,0,0,  7};
    vecs[21] = '{1,0,0,  1,0, 1,30, 7};
    vecs[22] = '{1,0,0,  1,1, 1,31, 8};
    vecs[23] = '{1,0,0,  1,2, 1,0,  9};
    vecs[24] = '{1,0,0,  1,3, 1,1,  10};

    // Reset state, with decode/redirect inputs active to show they are ignored.
    rst_n = 1'b0; ir_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 5'd17;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_imem_rd", 32'(imem_rd), 0);
    chk("rst_ir_valid", 32'(ir_valid), 0);
    chk("rst_ir_data", ir_data, 0);
    chk("rst_ir_pc", 32'(ir_pc), 0);
    chk("rst_fetch_count", 32'(fetch_count), 0);
    chk("rst_imem_addr", 32'(imem_addr), 4);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      ir_ready = vecs[i].rdy; redirect_valid = vecs[i].redir; redirect_pc = vecs[i].rpc;
      #1;
      chk($sformatf("vec%0d_imem_rd", i), 32'(imem_rd), 32'(vecs[i].e_rd));
      if (vecs[i].e_rd) chk($sformatf("vec%0d_imem_addr", i), 32'(imem_addr), 32'(vecs[i].e_addr));
      chk($sformatf("vec%0d_ir_valid", i), 32'(ir_valid), 32'(vecs[i].e_vld));
      if (vecs[i].e_vld) begin
        chk($sformatf("vec%0d_ir_pc", i), 32'(ir_pc), 32'(vecs[i].e_pc));
        chk($sformatf("vec%0d_ir_data", i), ir_data, mem_word(vecs[i].e_pc));
      end
      chk($sformatf("vec%0d_fetch_count", i), 32'(fetch_count), 32'(vecs[i].e_fc));
      @(negedge clk);
    end

    // Fill the buffer, then pulse reset for half a cycle.
    ir_ready = 1'b0; redirect_valid = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("full_imem_rd", 32'(imem_rd), 0);
    chk("full_ir_valid", 32'(ir_valid), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("pulse_imem_rd", 32'(imem_rd), 0);
    chk("pulse_ir_valid", 32'(ir_valid), 0);
    chk("pulse_ir_data", ir_data, 0);
    chk("pulse_ir_pc", 32'(ir_pc), 0);
    chk("pulse_fetch_count", 32'(fetch_count), 0);
    #2 rst_n = 1'b1;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk); #1;
      got = ir_valid;
    end
    chk("restart_valid", 32'(got), 1);
    chk("restart_ir_pc", 32'(ir_pc), 4);
    chk("restart_ir_data", ir_data, mem_word(5'd4));
    chk("restart_fetch_count", 32'(fetch_count), 0);

    // fetch_count wrap from all-ones.
    force dut.r_fetch_count = 16'hFFFF;
    #1 release dut.r_fetch_count;
    chk("fc_preload", 32'(fetch_count), 32'hFFFF);
    ir_ready = 1'b1;
    @(posedge clk); #1;
    ir_ready = 1'b0;
    chk("fc_wrap", 32'(fetch_count), 0);
    chk("fc_wrap_next_pc", 32'(ir_pc), 5);

    // Random traffic against a transfer-level model.
    @(negedge clk);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    exp_pc = '0; exp_fc = '0; since = 0; all_rdy = 1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      redirect_valid = (c == 0) || ($urandom_range(0, 11) == 0);
      redirect_pc    = 5'($urandom_range(0, 31));
      ir_ready       = ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd_fetch_count", 32'(fetch_count), 32'(exp_fc));
      if (redirect_valid) begin
        chk("rnd_redirect_valid", 32'(ir_valid), 0);
        exp_pc = redirect_pc; since = 0; all_rdy = 1;
      end else begin
        since++;
        if (since < 3) chk("rnd_early_valid", 32'(ir_valid), 0);
        else if (all_rdy) chk("rnd_throughput", 32'(ir_valid), 1);
        if (ir_valid && ir_ready) begin
          chk("rnd_ir_pc", 32'(ir_pc), 32'(exp_pc));
          chk("rnd_ir_data", ir_data, mem_word(exp_pc));
          exp_pc = exp_pc + 5'd1;
          exp_fc = exp_fc + 16'd1;
        end
        if (!ir_ready) all_rdy = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
